// File: rtl/matrix_scan_capture.sv
// Receive side of the 8x8 bicolour scan bus: debounces each row dwell, rebuilds the
// red/green frame in a shadow buffer and commits it for registered row readback.
module matrix_scan_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] row_in,
  input  logic [7:0] col_R_in,
  input  logic [7:0] col_G_in,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_R,
  output logic [7:0] rd_G,
  output logic       frame_valid,
  output logic       frame_pulse,
  output logic [7:0] frame_cnt,
  output logic       row_err,
  output logic       timeout
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_FIRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX    = TW'(FRAME_TIMEOUT);

  logic [23:0]     sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [7:0][7:0] shadow_r_q, shadow_r_d, shadow_g_q, shadow_g_d;
  logic [7:0][7:0] comm_r_q, comm_r_d, comm_g_q, comm_g_d;
  logic [7:0]      seen_q, seen_d;
  logic            commit_q, commit_d;
  logic            frame_valid_q, frame_valid_d, frame_pulse_q, frame_pulse_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            row_err_q, row_err_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      rd_r_q, rd_r_d, rd_g_q, rd_g_d;

  logic [7:0] s_row, s_r, s_g;
  logic       same, stable_evt, row_ok, capture;
  logic [2:0] row_idx;

  always_comb begin
    sync1_d = {row_in, col_R_in, col_G_in};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    s_row   = sync2_q[23:16];
    s_r     = sync2_q[15:8];
    s_g     = sync2_q[7:0];
    same    = (sync2_q == prev_q);

    // Count saturates one past the fire value, so a long dwell fires only once.
    if (!same)                 stab_d = '0;
    else if (stab_q == STAB_MAX) stab_d = STAB_MAX;
    else                       stab_d = stab_q + SW'(1);
    stable_evt = same && (stab_q == STAB_FIRE);

    row_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!s_row[i]) row_idx = 3'(7 - i);
    end
    row_ok    = $onehot(~s_row);
    capture   = stable_evt && row_ok;
    row_err_d = stable_evt && !row_ok && (s_row != 8'hFF);

    shadow_r_d    = shadow_r_q;
    shadow_g_d    = shadow_g_q;
    comm_r_d      = comm_r_q;
    comm_g_d      = comm_g_q;
    seen_d        = seen_q;
    commit_d      = 1'b0;
    frame_pulse_d = 1'b0;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;

    if (capture) begin
      shadow_r_d[row_idx] = s_r;
      shadow_g_d[row_idx] = s_g;
      seen_d              = seen_q | (8'd1 << row_idx);
      commit_d            = (seen_d == 8'hFF);
    end

    // Commit lands one edge after the row that completed the set was written.
    if (commit_q) begin
      comm_r_d      = shadow_r_q;
      comm_g_d      = shadow_g_q;
      seen_d        = '0;
      frame_pulse_d = 1'b1;
      frame_valid_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 8'd1;
    end

    if (commit_q)              tcnt_d = '0;
    else if (tcnt_q == TO_MAX) tcnt_d = TO_MAX;
    else                       tcnt_d = tcnt_q + TW'(1);

    rd_r_d = comm_r_d[rd_addr];
    rd_g_d = comm_g_d[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      stab_q        <= '0;
      shadow_r_q    <= '0;
      shadow_g_q    <= '0;
      comm_r_q      <= '0;
      comm_g_q      <= '0;
      seen_q        <= '0;
      commit_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_pulse_q <= 1'b0;
      frame_cnt_q   <= '0;
      row_err_q     <= 1'b0;
      tcnt_q        <= '0;
      rd_r_q        <= '0;
      rd_g_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      shadow_r_q    <= shadow_r_d;
      shadow_g_q    <= shadow_g_d;
      comm_r_q      <= comm_r_d;
      comm_g_q      <= comm_g_d;
      seen_q        <= seen_d;
      commit_q      <= commit_d;
      frame_valid_q <= frame_valid_d;
      frame_pulse_q <= frame_pulse_d;
      frame_cnt_q   <= frame_cnt_d;
      row_err_q     <= row_err_d;
      tcnt_q        <= tcnt_d;
      rd_r_q        <= rd_r_d;
      rd_g_q        <= rd_g_d;
    end
  end

  assign rd_R        = rd_r_q;
  assign rd_G        = rd_g_q;
  assign frame_valid = frame_valid_q;
  assign frame_pulse = frame_pulse_q;
  assign frame_cnt   = frame_cnt_q;
  assign row_err     = row_err_q;
  assign timeout     = (tcnt_q == TO_MAX);

endmodule
